// File: rtl/w0rm_core_regfile_mp.sv
// w0rm_core_regfile_mp
// Multi-port register file for the W0RM core with optional write-to-read
// bypass, combinational or registered reads, and a per-register pending
// scoreboard that issue logic uses to spot registers with an outstanding write.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   rd_addr     packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data     packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_pending  pending flag of the register addressed by each read port
//   wr_enable   per-port write strobe
//   wr_addr     packed write addresses
//   wr_data     packed write data
//   rsv_enable  reserve strobe (mark rsv_addr pending)
//   rsv_addr    register to reserve
//   collision   registered pulse: two or more enabled in-range writes hit the
//               same address on the previous cycle
//
// Handshake: there is none. Every strobe (wr_enable, rsv_enable) is sampled
// at each rising edge and acts unconditionally; the file never back-pressures.
module w0rm_core_regfile_mp #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGISTERS   = 16,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter bit SINGLE_CYCLE    = 1'b1,
  parameter bit BYPASS          = 1'b1,
  parameter bit ZERO_REG        = 1'b0,
  localparam int ADDR_WIDTH     = $clog2(NUM_REGISTERS)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ_PORTS-1:0]             rd_pending,
  input  logic [NUM_WRITE_PORTS-1:0]            wr_enable,
  input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                                 rsv_enable,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr,
  output logic                                 collision
);

  logic [DATA_WIDTH-1:0]               regs   [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0]            pending;

  // Per-register view of this cycle's write ports.
  //   reg_hit : some enabled write targets the register (clears pending)
  //   reg_we  : the register actually changes (ZERO_REG drops r0 writes)
  //   reg_wd  : data of the highest-index port that targets it
  logic [NUM_REGISTERS-1:0]            reg_hit;
  logic [NUM_REGISTERS-1:0]            reg_we;
  logic [DATA_WIDTH-1:0]               reg_wd [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0]            rsv_hit;
  logic                                collision_next;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_comb;

  // Addresses are compared against each real register index, so write
  // addresses at or above NUM_REGISTERS simply match nothing: no state change
  // and no contribution to collision.
  always_comb begin
    collision_next = 1'b0;
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      reg_hit[r] = 1'b0;
      reg_we[r]  = 1'b0;
      reg_wd[r]  = '0;
      // Ascending port order: the last matching port (highest index) wins.
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (wr_enable[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
          if (reg_hit[r]) collision_next = 1'b1;
          reg_hit[r] = 1'b1;
          if (!(ZERO_REG && (r == 0))) begin
            reg_we[r] = 1'b1;
            reg_wd[r] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      rsv_hit[r] = rsv_enable && (rsv_addr == ADDR_WIDTH'(r)) && !(ZERO_REG && (r == 0));
    end
  end

  // Storage, scoreboard and collision pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGISTERS; r++) regs[r] <= '0;
      pending   <= '0;
      collision <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGISTERS; r++) begin
        if (reg_we[r]) regs[r] <= reg_wd[r];
        // A reserve in the same cycle as a write means a new producer was
        // issued, so the set takes priority over the clear.
        if (rsv_hit[r])      pending[r] <= 1'b1;
        else if (reg_hit[r]) pending[r] <= 1'b0;
      end
      collision <= collision_next;
    end
  end

  // Combinational read path; out-of-range addresses match no register and
  // therefore return 0 data and 0 pending.
  always_comb begin
    rd_comb    = '0;
    rd_pending = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      for (int r = 0; r < NUM_REGISTERS; r++) begin
        if (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
          rd_comb[i*DATA_WIDTH +: DATA_WIDTH] = (BYPASS && reg_we[r]) ? reg_wd[r] : regs[r];
          rd_pending[i] = pending[r] && !(BYPASS && reg_hit[r] && !rsv_hit[r]);
        end
      end
    end
  end

  generate
    if (SINGLE_CYCLE) begin : g_comb_read
      assign rd_data = rd_comb;
    end else begin : g_reg_read
      // Captures exactly what the combinational path shows, bypass included.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_data <= '0;
        else          rd_data <= rd_comb;
      end
    end
  endgenerate

endmodule

// File: tb/tb_w0rm_core_regfile_mp.sv
// Bench for w0rm_core_regfile_mp. Three instances share one stimulus stream:
//   k=0 dut_c : combinational read, bypass on, 16 registers
//   k=1 dut_r : registered read, bypass on, ZERO_REG, 12 registers (addr 12..15 out of range)
//   k=2 dut_n : combinational read, bypass off, 16 registers
// A behavioural model tracks register contents, pending bits and collision per
// instance; directed steps add fixed expected constants.
module tb_w0rm_core_regfile_mp;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int NRP = 2;
  localparam int NWP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NRP*AW-1:0] rd_addr = '0;
  logic [NWP-1:0]    wr_enable = '0;
  logic [NWP*AW-1:0] wr_addr = '0;
  logic [NWP*DW-1:0] wr_data = '0;
  logic              rsv_enable = 1'b0;
  logic [AW-1:0]     rsv_addr = '0;

  logic [NRP*DW-1:0] rd_data_c, rd_data_r, rd_data_n;
  logic [NRP-1:0]    rd_pending_c, rd_pending_r, rd_pending_n;
  logic              collision_c, collision_r, collision_n;

  w0rm_core_regfile_mp #(.NUM_REGISTERS(16), .SINGLE_CYCLE(1'b1), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_c (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_pending(rd_pending_c),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .collision(collision_c));

  w0rm_core_regfile_mp #(.NUM_REGISTERS(12), .SINGLE_CYCLE(1'b0), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_r (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_r), .rd_pending(rd_pending_r),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .collision(collision_r));

  w0rm_core_regfile_mp #(.NUM_REGISTERS(16), .SINGLE_CYCLE(1'b1), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pending(rd_pending_n),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .collision(collision_n));

  // ---------------- reference model ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0]    m_regs [3][16];
  bit               m_pend [3][16];
  bit               m_coll [3];
  logic [NRP*DW-1:0] m_rdq;
  logic [NRP*DW-1:0] exp_q [$];

  function automatic int  cfg_nr(int k); return (k == 1) ? 12 : 16; endfunction
  function automatic bit  cfg_by(int k); return (k != 2);          endfunction
  function automatic bit  cfg_zr(int k); return (k == 1);          endfunction

  function automatic int ra_of(int i); return int'(rd_addr[i*AW +: AW]); endfunction
  function automatic int wa_of(int p); return int'(wr_addr[p*AW +: AW]); endfunction

  // Value a read port should present this cycle before the edge.
  function automatic logic [DW-1:0] exp_read(int k, int i);
    int a;
    logic [DW-1:0] v;
    a = ra_of(i);
    if (a >= cfg_nr(k)) return '0;
    v = m_regs[k][a];
    if (cfg_by(k))
      for (int p = 0; p < NWP; p++)
        if (wr_enable[p] && wa_of(p) == a) v = wr_data[p*DW +: DW];
    if (cfg_zr(k) && a == 0) v = '0;
    return v;
  endfunction

  function automatic bit exp_pend(int k, int i);
    int a;
    bit wr_hit;
    a = ra_of(i);
    if (a >= cfg_nr(k)) return 1'b0;
    wr_hit = 1'b0;
    for (int p = 0; p < NWP; p++)
      if (wr_enable[p] && wa_of(p) == a) wr_hit = 1'b1;
    if (cfg_by(k) && wr_hit && !(rsv_enable && int'(rsv_addr) == a)) return 1'b0;
    return m_pend[k][a];
  endfunction

  function automatic logic [DW-1:0] obs_data(int k, int i);
    case (k)
      0:       return rd_data_c[i*DW +: DW];
      1:       return rd_data_r[i*DW +: DW];
      default: return rd_data_n[i*DW +: DW];
    endcase
  endfunction

  function automatic logic obs_pend(int k, int i);
    case (k)
      0:       return rd_pending_c[i];
      1:       return rd_pending_r[i];
      default: return rd_pending_n[i];
    endcase
  endfunction

  function automatic logic obs_coll(int k);
    case (k)
      0:       return collision_c;
      1:       return collision_r;
      default: return collision_n;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 16; r++) begin
        m_regs[k][r] = '0;
        m_pend[k][r] = 1'b0;
      end
      m_coll[k] = 1'b0;
    end
    m_rdq = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int a;
    exp_q.push_back({exp_read(1, 1), exp_read(1, 0)});
    for (int k = 0; k < 3; k++) begin
      m_coll[k] = 1'b0;
      for (int p = 0; p < NWP; p++)
        for (int q = p + 1; q < NWP; q++)
          if (wr_enable[p] && wr_enable[q] && wa_of(p) == wa_of(q) && wa_of(p) < cfg_nr(k))
            m_coll[k] = 1'b1;
      for (int p = 0; p < NWP; p++) begin
        a = wa_of(p);
        if (wr_enable[p] && a < cfg_nr(k)) begin
          m_pend[k][a] = 1'b0;
          if (!(cfg_zr(k) && a == 0)) m_regs[k][a] = wr_data[p*DW +: DW];
        end
      end
      a = int'(rsv_addr);
      if (rsv_enable && a < cfg_nr(k) && !(cfg_zr(k) && a == 0)) m_pend[k][a] = 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pre-edge check of everything combinational (and the held registered data).
  task automatic check_comb();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NRP; i++) begin
        if (k == 1) chk($sformatf("k1_p%0d_rdata_hold", i), 64'(obs_data(1, i)), 64'(m_rdq[i*DW +: DW]));
        else        chk($sformatf("k%0d_p%0d_rdata", k, i), 64'(obs_data(k, i)), 64'(exp_read(k, i)));
        chk($sformatf("k%0d_p%0d_pending", k, i), 64'(obs_pend(k, i)), 64'(exp_pend(k, i)));
      end
  endtask

  task automatic check_post();
    if (exp_q.size() > 0) m_rdq = exp_q.pop_front();
    chk("k1_rdata_captured", 64'(rd_data_r), 64'(m_rdq));
    for (int k = 0; k < 3; k++) chk($sformatf("k%0d_collision", k), 64'(obs_coll(k)), 64'(m_coll[k]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [1:0] en, input int wa0, input logic [31:0] wd0,
                        input int wa1, input logic [31:0] wd1,
                        input bit rsv, input int rsa, input int rd0, input int rd1);
    wr_enable  = en;
    wr_addr    = {AW'(wa1), AW'(wa0)};
    wr_data    = {wd1, wd0};
    rsv_enable = rsv;
    rsv_addr   = AW'(rsa);
    rd_addr    = {AW'(rd1), AW'(rd0)};
    #1;
  endtask

  task automatic idle(input int rd0, input int rd1);
    set_in(2'b00, 0, '0, 0, '0, 1'b0, 0, rd0, rd1);
  endtask

  // Inputs are applied just after a falling edge; this checks, crosses the
  // rising edge, updates the model, checks registered outputs and returns at
  // the next falling edge.
  task automatic cycle();
    check_comb();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check_post();
    @(negedge clk);
  endtask

  function automatic int rnd_addr();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, 15));
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_comb();
    check_post();
    chk("reset_rdata_r", 64'(rd_data_r), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Dual write, distinct addresses
    set_in(2'b11, 1, 32'h11, 2, 32'h22, 1'b0, 0, 0, 0);
    cycle();
    chk("dual_collision", 64'(collision_c), 64'h0);
    idle(1, 2);
    chk("dual_read", 64'(rd_data_c), {32'h22, 32'h11});
    chk("rreg_before_edge", 64'(rd_data_r[31:0]), 64'h0);
    cycle();
    chk("rreg_after_edge", 64'(rd_data_r[31:0]), 64'h11);

    // Write collision on r5
    set_in(2'b11, 5, 32'h33, 5, 32'h44, 1'b0, 0, 5, 5);
    cycle();
    chk("coll_pulse", 64'(collision_c), 64'h1);
    idle(5, 5);
    chk("coll_winner", 64'(rd_data_c[31:0]), 64'h44);
    cycle();
    chk("coll_drop", 64'(collision_c), 64'h0);

    // Bypass vs no bypass on r7
    set_in(2'b01, 7, 32'h5A, 0, '0, 1'b0, 0, 7, 7);
    chk("bypass_same_cycle", 64'(rd_data_c[31:0]), 64'h5A);
    chk("nobypass_old", 64'(rd_data_n[31:0]), 64'h0);
    cycle();
    idle(7, 7);
    chk("nobypass_next", 64'(rd_data_n[31:0]), 64'h5A);
    cycle();

    // Scoreboard on r4
    set_in(2'b00, 0, '0, 0, '0, 1'b1, 4, 4, 4);
    cycle();
    idle(4, 4);
    chk("rsv_set", 64'(rd_pending_c[0]), 64'h1);
    cycle();
    set_in(2'b01, 4, 32'h77, 0, '0, 1'b1, 4, 4, 4);
    chk("rsv_and_write_comb", 64'(rd_pending_c[0]), 64'h1);
    cycle();
    idle(4, 4);
    chk("rsv_wins", 64'(rd_pending_c[0]), 64'h1);
    cycle();
    set_in(2'b10, 0, '0, 4, 32'h78, 1'b0, 0, 4, 4);
    cycle();
    idle(4, 4);
    chk("write_clears", 64'(rd_pending_c[0]), 64'h0);
    cycle();

    // ZERO_REG: reserve and write r0
    set_in(2'b01, 0, 32'hFF, 0, '0, 1'b1, 0, 0, 0);
    cycle();
    idle(0, 0);
    chk("zr_pending", 64'(rd_pending_r[0]), 64'h0);
    chk("nzr_r0", 64'(rd_data_c[31:0]), 64'hFF);
    cycle();
    chk("zr_data", 64'(rd_data_r[31:0]), 64'h0);

    // Out-of-range for the 12-register instance (in range for the others)
    set_in(2'b11, 14, 32'hAB, 14, 32'hCD, 1'b1, 14, 14, 13);
    cycle();
    chk("oor_no_collision", 64'(collision_r), 64'h0);
    chk("inrange_collision", 64'(collision_c), 64'h1);
    idle(14, 14);
    chk("oor_pending", 64'(rd_pending_r[0]), 64'h0);
    cycle();
    chk("oor_rdata", 64'(rd_data_r[31:0]), 64'h0);

    // Reset mid-run
    set_in(2'b01, 3, 32'hA5, 0, '0, 1'b1, 3, 0, 0);
    cycle();
    idle(3, 3);
    cycle();
    chk("pre_reset_r3", 64'(rd_data_r[31:0]), 64'hA5);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_reset_r3", 64'(rd_data_c[31:0]), 64'h0);
    chk("mid_reset_rreg", 64'(rd_data_r), 64'h0);
    chk("mid_reset_pend", 64'({rd_pending_c, rd_pending_r, rd_pending_n}), 64'h0);
    chk("mid_reset_coll", 64'({collision_c, collision_r, collision_n}), 64'h0);
    @(negedge clk);
    idle(3, 3);
    cycle();
    reset_n = 1'b1;
    #1;

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      set_in(2'($urandom_range(0, 3)), rnd_addr(), $urandom, rnd_addr(), $urandom,
             bit'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
